fabint_ctrl: RTL

- Processor-facing end of the switch fabric-interrupt path.
- Captures active-low switch presses as latched pending bits and raises a level interrupt to the MSS.
- The CPU reads the cause over an APB3 slave port and write-1-clears it; the interrupt stays high until every enabled pending bit is cleared.
- Sits between the board switch pins and the MSS FABINT input, on the fabric APB bus.

---
 rtl/fabint_pkg.sv | 19 +
 rtl/fabint_edge_det.sv | 66 ++++++
 rtl/fabint_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/fabint_pkg.sv
// Shared register offsets, counter width and saturating add for the fabric-interrupt controller.
package fabint_pkg;

    localparam logic [3:0] STATUS_OFS = 4'h0;
    localparam logic [3:0] CLEAR_OFS  = 4'h4;
    localparam logic [3:0] ENABLE_OFS = 4'h8;
    localparam logic [3:0] COUNT_OFS  = 4'hC;

    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] base,
                                                   input logic [3:0] inc);
        logic [COUNT_W:0] sum;
        sum = {1'b0, base} + (COUNT_W + 1)'(inc);
        return sum[COUNT_W] ? COUNT_MAX : sum[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/fabint_edge_det.sv
// Per-switch synchronizer and press-edge detector; FABINT_DEBOUNCE_EN adds a stability filter.
module fabint_edge_det #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sw,
    output logic press
);

    logic sync1_q, sync2_q, sync3_q;
    logic press_q, press_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= ~sw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            press_q <= press_d;
        end
    end

`ifdef FABINT_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Count stable cycles of a sync2 value that differs from the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if ((sync2_q != sync3_q) || (sync2_q == level_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
`else
    assign press_d = sync2_q & ~sync3_q;
`endif

    assign press = press_q;

endmodule

// File: rtl/fabint_ctrl.sv
// Fabric-interrupt controller: latched switch presses, APB3 cause registers, level interrupt.
// Optional debounce via FABINT_DEBOUNCE_EN. The interrupt port is fab_int (int is a keyword).
module fabint_ctrl
    import fabint_pkg::*;
#(
    parameter int unsigned NUM_SRC         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] sw,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [3:0]         paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic               fab_int
);

    logic [NUM_SRC-1:0] press;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [COUNT_W-1:0] count_q, count_d, count_base;
    logic [31:0]        prdata_q, prdata_d, rdata;
    logic               int_q;
    logic [3:0]         n_evt;
    logic [3:0]         reg_addr;
    logic               wr_en, setup;
    logic               unused_bits;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fabint_edge_det #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_edge (
            .clock  (clock),
            .reset_n(reset_n),
            .sw     (sw[i]),
            .press  (press[i])
        );
    end

    assign reg_addr    = {paddr[3:2], 2'b00};
    assign wr_en       = psel & penable & pwrite;
    assign setup       = psel & ~penable;
    assign unused_bits = ^{paddr[1:0], pwdata};

    always_comb begin
        n_evt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            n_evt = n_evt + 4'(press[i]);
        end
    end

    always_comb begin
        // A new event always wins over a same-cycle clear.
        pending_d  = pending_q | press;
        enable_d   = enable_q;
        count_base = count_q;
        if (wr_en) begin
            case (reg_addr)
                CLEAR_OFS:  pending_d = (pending_q & ~pwdata[NUM_SRC-1:0]) | press;
                ENABLE_OFS: enable_d = pwdata[NUM_SRC-1:0];
                COUNT_OFS:  count_base = '0;
                default:    ;
            endcase
        end
        count_d = sat_add(count_base, n_evt);

        rdata = '0;
        case (reg_addr)
            STATUS_OFS: rdata[NUM_SRC-1:0] = pending_q;
            ENABLE_OFS: rdata[NUM_SRC-1:0] = enable_q;
            COUNT_OFS:  rdata[COUNT_W-1:0] = count_q;
            default:    ;
        endcase
        prdata_d = setup ? rdata : prdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            enable_q  <= '1;
            count_q   <= '0;
            prdata_q  <= '0;
            int_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            count_q   <= count_d;
            prdata_q  <= prdata_d;
            int_q     <= |(pending_q & enable_q);
        end
    end

    assign prdata  = prdata_q;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign fab_int = int_q;

endmodule
